pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
Parametrised inter-stage pipeline register for the LC-3b pipeline, generalising the fixed-width load/clear stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries one control word and one packed datapath word per entry, using a valid/ready handshake and a 2-entry skid buffer so in_ready is driven from a flop and never combinationally from out_ready. Adds a flush for branch/trap squash, bubble (NOP control) insertion when empty, an occupancy output and a stall-cycle counter.

Parameters:
DATA_W, 83, packed datapath width (pc, ir, reg_a, reg_b, alu = 5x16, plus 3-bit nzp)
CTRL_W, 30, width of the packed ctrl_struct word
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream stage presents an entry
in_ready  output  1  this stage can accept an entry (registered)
in_ctrl  input  CTRL_W  control word of the upstream entry
in_data  input  DATA_W  datapath word of the upstream entry
flush  input  1  squash all held entries (synchronous)
out_valid  output  1  output entry is valid
out_ready  input  1  downstream stage accepts the output entry
out_ctrl  output  CTRL_W  control word; all-zero (NOP) whenever out_valid=0
out_data  output  DATA_W  datapath word; holds its last value when out_valid=0
occupancy  output  2  number of held entries (0..2)
stall_count  output  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Storage: main slot (drives outputs) and skid slot, each with a valid flag. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid (flop-derived). out_valid = main_valid. occupancy = main_valid + skid_valid.
- States: EMPTY (0 held), ONE (main only), FULL (main + skid).
- EMPTY: in_fire -> ONE, main <= in. in_ready = 1.
- ONE: in_fire & out_fire -> ONE, main <= in. in_fire & !out_fire -> FULL, skid <= in. !in_fire & out_fire -> EMPTY. Otherwise hold.
- FULL: in_ready = 0. out_fire -> ONE, main <= skid, skid_valid <= 0. Otherwise hold.
- Latency: an entry accepted in cycle N is presented on the outputs in cycle N+1 when the stage is EMPTY or draining. Sustained throughput is 1 entry/cycle. Order is strictly FIFO.
- Flush: on the next edge both valid flags clear (-> EMPTY) and in_ready = 1. It takes priority over a same-cycle in_fire, whose entry is dropped. A same-cycle out_fire still counts as consumed downstream.
- Bubble: when out_valid = 0, out_ctrl = 0 (combinational mask). out_data is not masked.
- stall_count: increments by 1 each cycle with out_valid & !out_ready. Saturates at 2^CNT_W-1. Unaffected by flush; cleared only by reset.
- Reset (async, any time including mid-transfer): both valid flags = 0, main/skid data and ctrl = 0, stall_count = 0. Outputs immediately become out_valid = 0, out_ctrl = 0, out_data = 0, in_ready = 1, occupancy = 0.
- No X propagation from skid contents: the skid slot is only loaded on in_fire in state ONE.

Test Plan:
- Reset then idle: reset pulse mid-cycle -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, stall_count=0 without waiting for an edge.
- Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later; occupancy stays 1; in_ready never drops.
- Back-pressure: send A,B,C with out_ready=0 -> A in main, B in skid, occupancy=2, in_ready=0, C held upstream; raise out_ready -> outputs A,B,C in order with no loss or duplication; stall_count equals the number of stalled cycles.
- Flush while FULL with in_valid=1 (entry D) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; D never appears on the outputs.
- Bubble masking: in_ctrl=30'h3FFFFFFF accepted and consumed, then no input -> out_valid=0, out_ctrl=0, out_data retains the last value.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_count=15 and stays 15.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is derived from flops only; adds flush, NOP bubble masking and a stall counter.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 83,
  parameter int unsigned CTRL_W = 30,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CNT_W-1:0]  stall_q;

  logic main_valid, skid_valid;
  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d      = StOne;
          load_main_in = 1'b1;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_d   = StFull;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          state_d        = StOne;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over a same-cycle accept; the incoming entry is dropped.
    if (flush) begin
      state_d        = StEmpty;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready    = ~skid_valid;
    out_valid   = main_valid;
    out_ctrl    = main_valid ? main_ctrl_q : '0;
    out_data    = main_data_q;
    occupancy   = 2'(main_valid) + 2'(skid_valid);
    stall_count = stall_q;
  end

endmodule
